// File: rtl/speedtest_pkg.sv
// Shared types and constants for the XillyUSB speed-test pattern source.
package speedtest_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;
    localparam logic [31:0] LFSR_SEED = 32'hFFFFFFFF;

    // Right-shifting Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/speedtest_fifo.sv
// Synchronous non-FWFT FIFO with registered read data and a synchronous flush.
module speedtest_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] mem [DEPTH];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    always_ff @(posedge bus_clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // A pop coinciding with a flush still delivers its word; only the backlog is dropped.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (rd_en && !empty)
                rd_data <= mem[rd_ptr[AW-1:0]];
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en && !full)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_en && !empty)
                    rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/xillyusb_speedtest_src.sv
// Host-bound test-pattern source feeding the XillyUSB read_32 FIFO interface.
// SPEEDTEST_LFSR_EN selects an LFSR pattern instead of the incrementing counter.
module xillyusb_speedtest_src
    import speedtest_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic        user_r_read_32_open,
    input  logic        user_r_read_32_rden,
    output logic [31:0] user_r_read_32_data,
    output logic        user_r_read_32_empty,
    output logic        user_r_read_32_eof,
    input  logic [31:0] xfer_words,
    input  logic [7:0]  gap_cycles,
    output logic [31:0] words_sent,
    output logic        underrun_err
);
    state_t      state;
    logic        open_d;
    logic        open_rise;
    logic [31:0] limit;
    logic [31:0] gen_count;
    logic [31:0] pattern;
    logic [31:0] pattern_nxt;
    logic [31:0] pattern_seed;
    logic [7:0]  gap_cnt;
    logic        limit_hit;
    logic        wr_en;
    logic        flush;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;

`ifdef SPEEDTEST_LFSR_EN
    assign pattern_seed = LFSR_SEED;
    assign pattern_nxt  = lfsr_next(pattern);
`else
    assign pattern_seed = '0;
    assign pattern_nxt  = pattern + 32'd1;
`endif

    assign open_rise = user_r_read_32_open && !open_d;
    assign limit_hit = (limit != '0) && (gen_count == limit);
    assign wr_en     = (state == RUN) && !fifo_full && (gap_cnt == '0) && !limit_hit;
    assign flush     = !user_r_read_32_open || open_rise;

    assign user_r_read_32_empty = fifo_empty || (state == IDLE);
    assign user_r_read_32_eof   = (state == DONE) && fifo_empty;
    assign pop                  = user_r_read_32_rden && !user_r_read_32_empty;

    speedtest_fifo #(.DEPTH(DEPTH)) u_fifo (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (pattern),
        .rd_en     (pop),
        .rd_data   (user_r_read_32_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state  <= IDLE;
            open_d <= 1'b0;
            limit  <= '0;
        end else begin
            open_d <= user_r_read_32_open;
            if (!user_r_read_32_open) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (open_rise) begin
                        state <= RUN;
                        limit <= xfer_words;
                    end
                    RUN:  if (limit_hit) state <= DONE;
                    default: state <= state;
                endcase
            end
        end
    end

    // The gap counter is only reloaded by an accepted write, so a full FIFO leaves it idle at 0.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            gen_count <= '0;
            pattern   <= '0;
            gap_cnt   <= '0;
        end else if (open_rise) begin
            gen_count <= '0;
            pattern   <= pattern_seed;
            gap_cnt   <= '0;
        end else if (wr_en) begin
            gen_count <= gen_count + 32'd1;
            pattern   <= pattern_nxt;
            gap_cnt   <= gap_cycles;
        end else if (gap_cnt != '0) begin
            gap_cnt   <= gap_cnt - 8'd1;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            words_sent   <= '0;
            underrun_err <= 1'b0;
        end else if (open_rise) begin
            words_sent   <= '0;
            underrun_err <= 1'b0;
        end else begin
            if (pop && (words_sent != 32'hFFFFFFFF))
                words_sent <= words_sent + 32'd1;
            if (user_r_read_32_rden && user_r_read_32_empty)
                underrun_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xillyusb_speedtest_src.sv
// Self-checking bench for xillyusb_speedtest_src against a word-sequence reference model.
module tb_xillyusb_speedtest_src;

    localparam int DEPTH = 16;

    logic        bus_clk = 1'b0;
    logic        bus_rst_n;
    logic        user_r_read_32_open;
    logic        user_r_read_32_rden;
    logic [31:0] user_r_read_32_data;
    logic        user_r_read_32_empty;
    logic        user_r_read_32_eof;
    logic [31:0] xfer_words;
    logic [7:0]  gap_cycles;
    logic [31:0] words_sent;
    logic        underrun_err;

    int total = 0;
    int bad   = 0;

    int unsigned pop_idx    = 0;
    int unsigned exp_sent   = 0;
    logic        exp_under  = 1'b0;
    logic        pend_pop   = 1'b0;
    logic        popped_now = 1'b0;
    logic        cur_open   = 1'b0;
    int          cyc        = 0;
    int          last_pop_t = 0;
    int          prev_pop_t = 0;

    xillyusb_speedtest_src #(.DEPTH(DEPTH)) dut (
        .bus_clk              (bus_clk),
        .bus_rst_n            (bus_rst_n),
        .user_r_read_32_open  (user_r_read_32_open),
        .user_r_read_32_rden  (user_r_read_32_rden),
        .user_r_read_32_data  (user_r_read_32_data),
        .user_r_read_32_empty (user_r_read_32_empty),
        .user_r_read_32_eof   (user_r_read_32_eof),
        .xfer_words           (xfer_words),
        .gap_cycles           (gap_cycles),
        .words_sent           (words_sent),
        .underrun_err         (underrun_err)
    );

    always #5 bus_clk = ~bus_clk;

    // Word number idx of a session, computed directly from the pattern definition.
    function automatic logic [31:0] exp_word(input int unsigned idx);
`ifdef SPEEDTEST_LFSR_EN
        logic [31:0] s = 32'hFFFFFFFF;
        for (int unsigned i = 0; i < idx; i++)
            s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
        return s;
`else
        return idx;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: settle the previous pop, check running state, drive this cycle's inputs.
    task automatic tick(input logic rd, input logic op);
        @(negedge bus_clk);
        cyc++;
        if (pend_pop) begin
            chk($sformatf("data[%0d]", pop_idx), user_r_read_32_data, exp_word(pop_idx));
            pop_idx++;
            exp_sent++;
        end
        chk("words_sent", words_sent, exp_sent);
        chk("underrun", {31'd0, underrun_err}, {31'd0, exp_under});
        chk("eof_without_empty", {31'd0, user_r_read_32_eof & ~user_r_read_32_empty}, 32'd0);
        if (op && !cur_open) begin
            exp_under = 1'b0;
            pop_idx   = 0;
            exp_sent  = 0;
        end else if (rd && user_r_read_32_empty) begin
            exp_under = 1'b1;
        end
        pend_pop   = rd && !user_r_read_32_empty;
        popped_now = pend_pop;
        if (pend_pop) begin
            prev_pop_t = last_pop_t;
            last_pop_t = cyc;
        end
        user_r_read_32_rden = rd;
        user_r_read_32_open = op;
        cur_open = op;
    endtask

    initial begin
        int          n;
        logic        done;
        int unsigned rx;

        bus_rst_n           = 1'b0;
        user_r_read_32_open = 1'b0;
        user_r_read_32_rden = 1'b0;
        xfer_words          = '0;
        gap_cycles          = '0;
        #23;
        bus_rst_n = 1'b1;

        @(negedge bus_clk);
        chk("rst_empty", {31'd0, user_r_read_32_empty}, 32'd1);
        chk("rst_eof", {31'd0, user_r_read_32_eof}, 32'd0);
        chk("rst_data", user_r_read_32_data, 32'd0);
        chk("rst_sent", words_sent, 32'd0);
        chk("rst_underrun", {31'd0, underrun_err}, 32'd0);

        // Limited session read at full rate.
        xfer_words = 32'd5;
        gap_cycles = 8'd0;
        tick(1'b0, 1'b1);
        repeat (10) tick(1'b1, 1'b1);
        chk("t1_pops", pop_idx, 32'd5);
        chk("t1_eof", {31'd0, user_r_read_32_eof}, 32'd1);
        chk("t1_empty", {31'd0, user_r_read_32_empty}, 32'd1);
        chk("t1_sent", words_sent, 32'd5);
        chk("t1_underrun_sticky", {31'd0, underrun_err}, 32'd1);

        // Unlimited session with gaps and no reads fills the FIFO, then paced draining.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        xfer_words = 32'd0;
        gap_cycles = 8'd3;
        tick(1'b0, 1'b1);
        repeat (100) tick(1'b0, 1'b1);
        chk("t2_full", {31'd0, dut.u_fifo.full}, 32'd1);
        chk("t2_empty", {31'd0, user_r_read_32_empty}, 32'd0);
        chk("t2_eof", {31'd0, user_r_read_32_eof}, 32'd0);
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, 1'b1);
            n += int'(popped_now);
        end
        chk("t2_backlog_pops", n, DEPTH);
        repeat (44) tick(1'b1, 1'b1);
        chk("t2_spacing", last_pop_t - prev_pop_t, 32'd4);

        // Underrun at session start; flag cleared by the reopen.
        tick(1'b0, 1'b0);
        gap_cycles = 8'd0;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        chk("t3_cleared", {31'd0, underrun_err}, 32'd0);
        tick(1'b0, 1'b1);
        chk("t3_underrun", {31'd0, underrun_err}, 32'd1);
        chk("t3_sent", words_sent, 32'd0);

        // Close after three pops, then reopen.
        repeat (3) tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("t4_empty_closed", {31'd0, user_r_read_32_empty}, 32'd1);
        chk("t4_sent_held", words_sent, 32'd3);
        tick(1'b0, 1'b1);
        repeat (5) tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        chk("t4_sent_restart", words_sent, 32'd4);

        // Simultaneous pop and write at half-full keeps occupancy at DEPTH/2.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        xfer_words = 32'd24;
        tick(1'b0, 1'b1);
        repeat (DEPTH / 2) tick(1'b0, 1'b1);
        repeat (16) tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("t5_empty", {31'd0, user_r_read_32_empty}, 32'd0);
        chk("t5_eof", {31'd0, user_r_read_32_eof}, 32'd0);
        n = 0;
        repeat (12) begin
            tick(1'b1, 1'b1);
            n += int'(popped_now);
        end
        tick(1'b0, 1'b1);
        chk("t5_occupancy", n, DEPTH / 2);
        chk("t5_eof_end", {31'd0, user_r_read_32_eof}, 32'd1);
        chk("t5_sent", words_sent, 32'd24);

        // Randomized session: random limit, gaps and read strobes.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rx = $urandom_range(30, 1);
        xfer_words = rx;
        tick(1'b0, 1'b1);
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            gap_cycles = 8'($urandom_range(2, 0));
            tick(1'($urandom_range(1, 0)), 1'b1);
            done = user_r_read_32_eof;
        end
        chk("rand_budget", {31'd0, done}, 32'd1);
        tick(1'b0, 1'b1);
        chk("rand_pops", pop_idx, rx);
        chk("rand_sent", words_sent, rx);
        chk("rand_empty", {31'd0, user_r_read_32_empty}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
